// File: rtl/cdctl_pll_pkg.sv
// cdctl_pll_pkg: shared types and default constants for the CDCTL PLL
// bring-up and supervision sequencer.
package cdctl_pll_pkg;

  // Sequencer states. BYPASS is only reachable when the design is built
  // with CDCTL_PLL_BYPASS_FALLBACK_EN.
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4,
    BYPASS    = 3'd5
  } pll_state_e;

  // Default timing for a 16 MHz reference clock.
  localparam int unsigned DEF_RST_HOLD     = 16;
  localparam int unsigned DEF_LOCK_STABLE  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT = 16384;
  localparam int unsigned DEF_LOSS_FILTER  = 4;
  localparam int unsigned DEF_MAX_RETRY    = 3;

  // Increment an 8-bit event counter, holding at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/cdctl_sync2.sv
// cdctl_sync2: generic two-flop synchronizer with synchronous active-high
// reset. Only q may be consumed in the destination clock domain.
module cdctl_sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture of the asynchronous input to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/cdctl_pll_ctrl.sv
// cdctl_pll_ctrl: bring-up and supervision sequencer for the iCE40 PLL that
// makes the 40 MHz CDCTL core clock from the 16 MHz reference. Runs on the
// reference clock, drives PLL RESETB, filters LOCK, retries on timeout,
// watches for lock loss and holds the core reset until the clock is proven.
// Optional feature macro: CDCTL_PLL_BYPASS_FALLBACK_EN -- after MAX_RETRY
// failed attempts, run the core on the reference clock (PLL bypass) instead
// of parking in FAIL.
module cdctl_pll_ctrl
  import cdctl_pll_pkg::*;
#(
  parameter int unsigned RST_HOLD     = DEF_RST_HOLD,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOSS_FILTER  = DEF_LOSS_FILTER,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int LW = $clog2(LOSS_FILTER + 1);

  // Terminal counts. The lock_s sample that moves WAIT_LOCK into STABLE is
  // the first of the LOCK_STABLE good cycles, so STABLE itself only needs
  // LOCK_STABLE-1 more; the counter is cleared on entry, hence the -2.
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 2);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_FILTER - 1);
  localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRY);

`ifdef CDCTL_PLL_BYPASS_FALLBACK_EN
  localparam pll_state_e GIVE_UP_STATE = BYPASS;
  localparam logic       GIVE_UP_BYP   = 1'b1;
`else
  localparam pll_state_e GIVE_UP_STATE = FAIL;
  localparam logic       GIVE_UP_BYP   = 1'b0;
`endif

  // Parameter sanity, checked at elaboration.
  if (LOCK_STABLE >= LOCK_TIMEOUT) begin : g_bad_stable_vs_timeout
    $error("cdctl_pll_ctrl: LOCK_STABLE must be less than LOCK_TIMEOUT");
  end
  if (LOCK_STABLE < 2) begin : g_bad_stable
    $error("cdctl_pll_ctrl: LOCK_STABLE must be at least 2");
  end
  if (RST_HOLD < 1 || LOSS_FILTER < 1) begin : g_bad_hold_or_filter
    $error("cdctl_pll_ctrl: RST_HOLD and LOSS_FILTER must be at least 1");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
    $error("cdctl_pll_ctrl: MAX_RETRY must be in 1..7");
  end

  pll_state_e      state_r;
  logic [HW-1:0]   hold_cnt_r;
  logic [SW-1:0]   stable_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic [LW-1:0]   unlock_cnt_r;
  logic            lock_s;
  logic [2:0]      retry_next_s;
  logic            give_up_s;
  logic            tmo_hit_s;
  logic            loss_s;

  cdctl_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_next_s = retry_cnt + 3'd1;
  assign give_up_s    = (retry_next_s == RETRY_MAX);
  assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
  assign loss_s       = !lock_s && (unlock_cnt_r == LOSS_LAST);

  // Sequencer state, counters and registered outputs in one process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= HOLD;
      hold_cnt_r   <= '0;
      stable_cnt_r <= '0;
      tmo_cnt_r    <= '0;
      unlock_cnt_r <= '0;
      pll_resetb   <= 1'b0;
      pll_bypass   <= 1'b0;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fail         <= 1'b0;
      retry_cnt    <= 3'd0;
      lost_cnt     <= 8'd0;
    end else begin
      case (state_r)
        HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= WAIT_LOCK;
            hold_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            pll_resetb <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1'b1);
          end
        end

        WAIT_LOCK: begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
          if (tmo_hit_s) begin
            // Attempt failed: retry from HOLD or give up.
            retry_cnt  <= retry_next_s;
            hold_cnt_r <= '0;
            state_r    <= give_up_s ? GIVE_UP_STATE : HOLD;
            pll_resetb <= give_up_s & GIVE_UP_BYP;
            pll_bypass <= give_up_s & GIVE_UP_BYP;
            fail       <= give_up_s;
          end else if (lock_s) begin
            state_r      <= STABLE;
            stable_cnt_r <= '0;
          end
        end

        STABLE: begin
          // Timer keeps running: the budget covers the whole attempt.
          tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
          if (lock_s && (stable_cnt_r == STABLE_LAST)) begin
            state_r      <= RUN;
            sys_rst      <= 1'b0;
            ready        <= 1'b1;
            retry_cnt    <= 3'd0;
            unlock_cnt_r <= '0;
          end else if (tmo_hit_s) begin
            retry_cnt  <= retry_next_s;
            hold_cnt_r <= '0;
            state_r    <= give_up_s ? GIVE_UP_STATE : HOLD;
            pll_resetb <= give_up_s & GIVE_UP_BYP;
            pll_bypass <= give_up_s & GIVE_UP_BYP;
            fail       <= give_up_s;
          end else if (!lock_s) begin
            state_r      <= WAIT_LOCK;
            stable_cnt_r <= '0;
          end else begin
            stable_cnt_r <= stable_cnt_r + SW'(1'b1);
          end
        end

        RUN: begin
          // Loss and relock in the same cycle collapse into one HOLD entry.
          if (loss_s || relock_req) begin
            if (loss_s) begin
              lost_cnt <= sat_inc8(lost_cnt);
            end
            state_r      <= HOLD;
            hold_cnt_r   <= '0;
            unlock_cnt_r <= '0;
            pll_resetb   <= 1'b0;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
          end else if (!lock_s) begin
            unlock_cnt_r <= unlock_cnt_r + LW'(1'b1);
          end else begin
            unlock_cnt_r <= '0;
          end
        end

        FAIL: begin
          if (relock_req) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
            retry_cnt  <= 3'd0;
            fail       <= 1'b0;
          end
        end

`ifdef CDCTL_PLL_BYPASS_FALLBACK_EN
        BYPASS: begin
          // Core runs on the reference clock; lock is not monitored here.
          if (relock_req) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
            retry_cnt  <= 3'd0;
            pll_resetb <= 1'b0;
            pll_bypass <= 1'b0;
            fail       <= 1'b0;
            ready      <= 1'b0;
            sys_rst    <= 1'b1;
          end else if (!ready) begin
            if (hold_cnt_r == HOLD_LAST) begin
              sys_rst <= 1'b0;
              ready   <= 1'b1;
            end else begin
              hold_cnt_r <= hold_cnt_r + HW'(1'b1);
            end
          end
        end
`endif

        default: begin
          state_r    <= HOLD;
          hold_cnt_r <= '0;
          pll_resetb <= 1'b0;
          pll_bypass <= 1'b0;
          sys_rst    <= 1'b1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cdctl_pll_ctrl.md
# cdctl_pll_ctrl

PLL bring-up and supervision sequencer for the iCE40 PLL that generates the 40 MHz CDCTL core clock from the 16 MHz reference. It runs on the free-running reference clock and drives the PLL's active-low reset. It filters the asynchronous LOCK output, retries with a timeout, detects lock loss in service and holds the core-domain reset until the clock is proven stable.

## Interface
Parameters:
- RST_HOLD, 16: cycles pll_resetb is held low per attempt
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release
- LOCK_TIMEOUT, 16384: cycles allowed from pll_resetb rise to reaching RUN
- LOSS_FILTER, 4: consecutive unlocked cycles in RUN that count as lock loss
- MAX_RETRY, 3: failed attempts before giving up

Ports:
- clk  in  1  reference clock (16 MHz); the sole clock of the block
- reset  in  1  synchronous, active-high
- pll_lock  in  1  PLL LOCK, asynchronous to clk
- relock_req  in  1  single-cycle request to restart the PLL
- pll_resetb  out  1  to PLL RESETB, active low
- pll_bypass  out  1  to PLL BYPASS
- sys_rst  out  1  active-high reset request for core-clock logic
- ready  out  1  clock usable
- fail  out  1  bring-up failed or degraded
- retry_cnt  out  3  failed attempts in the current bring-up
- lost_cnt  out  8  lock-loss events, saturating at 255

## Operation
- pll_lock passes through a 2-flop synchronizer to produce lock_s. All decisions use lock_s.
- HOLD:
  - pll_resetb=0, sys_rst=1.
  - After RST_HOLD cycles, go to WAIT_LOCK and set pll_resetb=1.
  - The timeout timer clears on entry.
- WAIT_LOCK:
  - The timeout timer runs.
  - lock_s=1: go to STABLE with the stable counter cleared.
  - Timer reaches LOCK_TIMEOUT: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to HOLD.
- STABLE:
  - The timeout timer keeps running and is not cleared.
  - lock_s=0: go to WAIT_LOCK and clear the stable counter.
  - Stable counter reaches LOCK_STABLE: go to RUN and clear retry_cnt.
  - Timeout in STABLE is handled exactly as in WAIT_LOCK.
- RUN:
  - sys_rst=0, ready=1.
  - An unlock counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - Unlock counter reaches LOSS_FILTER: lost_cnt+1 (saturating), then go to HOLD.
  - relock_req: go to HOLD.
  - relock_req and lock loss in the same cycle: one transition to HOLD, and lost_cnt still increments.
- FAIL:
  - pll_resetb=0, sys_rst=1, fail=1.
  - relock_req clears retry_cnt and fail, then goes to HOLD.
- relock_req is ignored in HOLD, WAIT_LOCK and STABLE.
- Counter widths: $clog2(param+1). LOCK_STABLE must be less than LOCK_TIMEOUT; this is elaboration-time checked.

## Timing
- Reset values:
  - state=HOLD, pll_resetb=0, pll_bypass=0, sys_rst=1, ready=0, fail=0.
  - retry_cnt=0, lost_cnt=0; all counters and synchronizer flops are 0.
- Reset asserted mid-operation returns everything to these values on the next edge, including lost_cnt.
- All outputs are registered and change on the same edge as the state register.
  - pll_resetb rises RST_HOLD cycles after HOLD entry.
  - sys_rst falls and ready rises on the edge that enters RUN.
- Latency from pll_lock rise to lock_s: 2 cycles. Fastest release after pll_resetb rise is (lock delay + 2 + LOCK_STABLE) cycles.
- Lock-loss reaction: pll_resetb falls LOSS_FILTER+2 cycles after pll_lock falls, and sys_rst rises on the same edge.

## Configuration
- CDCTL_PLL_BYPASS_FALLBACK_EN defined:
  - Reaching MAX_RETRY enters BYPASS instead of FAIL.
  - In BYPASS: pll_bypass=1, pll_resetb=1, fail=1; sys_rst is released after RST_HOLD cycles, then ready=1 (core runs on the reference clock).
  - Lock monitoring is off in BYPASS.
  - relock_req clears pll_bypass, fail and ready, sets sys_rst=1, clears retry_cnt and goes to HOLD.
- Not defined: pll_bypass is tied 0 and FAIL behaves as specified above.

## Structure
- Package cdctl_pll_pkg holds:
  - the state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAIL, BYPASS);
  - default parameter constants.
- Sub-module cdctl_sync2: generic 2-flop synchronizer with synchronous active-high reset. It is used for pll_lock and is reusable elsewhere.

## Test plan
Bench parameters: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, LOSS_FILTER=3, MAX_RETRY=2.
- Clean bring-up:
  - Stimulus: release reset; raise pll_lock 10 cycles after pll_resetb rises.
  - Required: pll_resetb rises at cycle 4; RUN, sys_rst=0 and ready=1 at cycle 4+10+2+8; retry_cnt=0.
- Lock glitch in STABLE:
  - Stimulus: drop pll_lock for 1 cycle after 5 stable cycles.
  - Required: stable counter restarts; RUN reached 8 cycles after lock_s returns.
- Timeout and fail:
  - Stimulus: hold pll_lock=0.
  - Required: two attempts; retry_cnt reaches 2; FAIL with fail=1, pll_resetb=0.
  - Then pulse relock_req and apply a good lock: RUN reached, retry_cnt=0.
- Lock loss in RUN:
  - Stimulus: 2-cycle low pulse on pll_lock → no action.
  - Stimulus: 3-cycle low → lost_cnt=1, sys_rst=1, HOLD.
  - Stimulus: 260 loss events → lost_cnt=255.
- Simultaneous relock_req and loss in RUN:
  - Required: single HOLD entry; lost_cnt increments by exactly 1.
- Bypass fallback, with CDCTL_PLL_BYPASS_FALLBACK_EN:
  - Stimulus: no lock.
  - Required: BYPASS with pll_bypass=1, fail=1; ready=1 after 4 more cycles.
  - Stimulus: relock_req → pll_bypass=0, HOLD.
